// File: rtl/cw_bin2cw_encoder_pkg.sv
// rtl/cw_bin2cw_encoder_pkg.sv - shared constants, FSM encoding and d/u selection table
package cw_bin2cw_encoder_pkg;

  // Default datapath widths: n up to 65536, t up to 9, 16-bit gaps.
  localparam int NW_DEF      = 17;
  localparam int TW_DEF      = 4;
  localparam int GW_DEF      = 16;

  // Width of u and the bounds on the chosen power of two.
  localparam int UW          = 4;
  localparam int U_MIN       = 2;
  localparam int U_MAX       = 15;

  // theta scales n in sixteenths before the power-of-two search.
  localparam int THETA_SHIFT = 4;

  localparam logic [7:0] BU_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_DSEL    = 3'd2,
    ST_FLAG    = 3'd3,
    ST_READIDX = 3'd4,
    ST_EMIT    = 3'd5,
    ST_FILL    = 3'd6,
    ST_DONE    = 3'd7
  } enc_state_t;

  // Per-weight scale factor; the decoder side must use the identical table.
  function automatic logic [THETA_SHIFT-1:0] theta_of(input logic [31:0] t);
    logic [THETA_SHIFT-1:0] th;
    if (t >= 32'd6)      th = 4'd1;
    else if (t >= 32'd4) th = 4'd2;
    else if (t == 32'd3) th = 4'd3;
    else if (t == 32'd2) th = 4'd4;
    else                 th = 4'd8;
    return th;
  endfunction

endpackage

// File: rtl/cw_bin2cw_encoder_dsel.sv
// rtl/cw_bin2cw_encoder_dsel.sv - cw_dsel: (n,t) -> (d,u) with fixed 2-cycle latency
module cw_bin2cw_encoder_dsel
  import cw_bin2cw_encoder_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int TW = TW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] n,
  input  logic [TW-1:0] t,
  output logic [GW-1:0] d,
  output logic [UW-1:0] u
);

  logic [NW-1:0]             n_q;
  logic [TW-1:0]             t_q;
  logic [THETA_SHIFT-1:0]    theta;
  logic [NW+THETA_SHIFT-1:0] prod;
  logic [NW-1:0]             q;
  logic [UW-1:0]             u_c;

  // Input stage: operands captured every cycle so the caller only has to hold n/t steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= '0;
      t_q <= '0;
    end else begin
      n_q <= n;
      t_q <= t;
    end
  end

  // q = (n*theta)>>4, then u = largest k in 3..15 with q > 2^(k-1), floor at U_MIN.
  always_comb begin
    theta = theta_of(32'(t_q));
    prod  = {{THETA_SHIFT{1'b0}}, n_q} * {{NW{1'b0}}, theta};
    q     = prod[NW+THETA_SHIFT-1:THETA_SHIFT];
    u_c   = UW'(U_MIN);
    for (int k = U_MIN + 1; k <= U_MAX; k++) begin
      if (32'(q) > (32'd1 << (k - 1))) begin
        u_c = UW'(k);
      end
    end
  end

  // Output stage: d is always a power of two matching u.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
      u <= '0;
    end else begin
      d <= GW'(1) << u_c;
      u <= u_c;
    end
  end

endmodule

// File: rtl/cw_bin2cw_encoder.sv
// rtl/cw_bin2cw_encoder.sv - serial bits to constant-weight gap lengths
module cw_bin2cw_encoder
  import cw_bin2cw_encoder_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int TW = TW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_init,
  input  logic [TW-1:0] t_init,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [GW-1:0] pos_data,
  output logic          pos_valid,
  output logic          pos_last,
  input  logic          pos_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    bits_used
);

  enc_state_t    state, state_nx;

  logic [NW-1:0] n_r;
  logic [TW-1:0] t_r;
  logic [GW-1:0] delta_r;
  logic [GW-1:0] idx_r;
  logic [UW-1:0] ucnt_r;
  logic          dsel_ph_r;

  logic [GW-1:0] sel_d;
  logic [UW-1:0] sel_u;

  logic [NW-1:0] slack;
  logic          d_fits;
  logic [GW-1:0] idx_shift;
  logic [GW-1:0] idx_clamp;
  logic          bit_take;
  logic          pos_take;

  cw_bin2cw_encoder_dsel #(
    .NW(NW),
    .TW(TW),
    .GW(GW)
  ) u_dsel (
    .clk (clk),
    .rst (rst),
    .n   (n_r),
    .t   (t_r),
    .d   (sel_d),
    .u   (sel_u)
  );

  assign bit_take = bit_valid & bit_ready;
  assign pos_take = pos_valid & pos_ready;

  // Slack n-t bounds both the skip decision and the index clamp, so n never underflows.
  always_comb begin
    slack     = n_r - NW'(t_r);
    d_fits    = (NW'(sel_d) <= slack);
    idx_shift = {idx_r[GW-2:0], bit_in};
    idx_clamp = (NW'(idx_shift) > slack) ? GW'(slack) : idx_shift;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake/output drive.
  always_comb begin
    state_nx  = state;
    bit_ready = 1'b0;
    pos_valid = 1'b0;
    pos_data  = '0;
    pos_last  = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (t_r == '0)                state_nx = ST_DONE;
        else if (n_r <= NW'(t_r))     state_nx = ST_FILL;
        else                          state_nx = ST_DSEL;
      end
      ST_DSEL: begin
        // Second cycle: d/u now reflect the current n/t.
        if (dsel_ph_r) state_nx = d_fits ? ST_FLAG : ST_READIDX;
      end
      ST_FLAG: begin
        bit_ready = 1'b1;
        if (bit_valid) state_nx = bit_in ? ST_CHECK : ST_READIDX;
      end
      ST_READIDX: begin
        bit_ready = 1'b1;
        if (bit_valid && (ucnt_r == UW'(1))) state_nx = ST_EMIT;
      end
      ST_EMIT: begin
        pos_valid = 1'b1;
        pos_data  = delta_r + idx_r;
        pos_last  = (t_r == TW'(1));
        if (pos_ready) state_nx = ST_CHECK;
      end
      ST_FILL: begin
        pos_valid = 1'b1;
        pos_data  = delta_r;
        pos_last  = (t_r == TW'(1));
        if (pos_ready && (t_r == TW'(1))) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Word registers: n/t/delta/index and the u-bit down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r       <= '0;
      t_r       <= '0;
      delta_r   <= '0;
      idx_r     <= '0;
      ucnt_r    <= '0;
      dsel_ph_r <= 1'b0;
    end else begin
      dsel_ph_r <= (state == ST_DSEL) ? ~dsel_ph_r : 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_r     <= n_init;
            t_r     <= t_init;
            delta_r <= '0;
            idx_r   <= '0;
          end
        end
        ST_DSEL: begin
          if (dsel_ph_r && !d_fits) begin
            ucnt_r <= sel_u;
            idx_r  <= '0;
          end
        end
        ST_FLAG: begin
          if (bit_valid) begin
            if (bit_in) begin
              n_r     <= n_r - NW'(sel_d);
              delta_r <= delta_r + sel_d;
            end else begin
              ucnt_r <= sel_u;
              idx_r  <= '0;
            end
          end
        end
        ST_READIDX: begin
          if (bit_valid) begin
            ucnt_r <= ucnt_r - UW'(1);
            idx_r  <= (ucnt_r == UW'(1)) ? idx_clamp : idx_shift;
          end
        end
        ST_EMIT: begin
          if (pos_ready) begin
            n_r     <= n_r - NW'(idx_r) - NW'(1);
            t_r     <= t_r - TW'(1);
            delta_r <= '0;
          end
        end
        ST_FILL: begin
          if (pos_ready) begin
            n_r     <= (n_r != '0) ? n_r - NW'(1) : n_r;
            t_r     <= t_r - TW'(1);
            delta_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Consumed-bit counter for the current word, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   bits_used <= 8'd0;
    else if ((state == ST_IDLE) && start)      bits_used <= 8'd0;
    else if (bit_take && (bits_used != BU_MAX)) bits_used <= bits_used + 8'd1;
  end

endmodule

// File: tb/tb_cw_bin2cw_encoder.sv
// tb/tb_cw_bin2cw_encoder.sv - self-checking bench for cw_bin2cw_encoder
module tb_cw_bin2cw_encoder;

  localparam int NW = 17;
  localparam int TW = 4;
  localparam int GW = 16;
  localparam int SRC_N = 4096;
  localparam int WORD_LIMIT = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] n_init = '0;
  logic [TW-1:0] t_init = '0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [GW-1:0] pos_data;
  logic          pos_valid;
  logic          pos_last;
  logic          pos_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [7:0]    bits_used;

  cw_bin2cw_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_init    (n_init),
    .t_init    (t_init),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .pos_data  (pos_data),
    .pos_valid (pos_valid),
    .pos_last  (pos_last),
    .pos_ready (pos_ready),
    .busy      (busy),
    .done      (done),
    .bits_used (bits_used)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit src [SRC_N];
  int ptr = 0;
  int feed_lim = SRC_N;
  bit feed_en = 1'b0;
  bit bv_rand = 1'b1;
  int pr_mode = 1;
  bit seen_br = 1'b0;
  bit hold_prev = 1'b0;
  logic [GW-1:0] held_data;
  logic held_last;

  int got_q[$];
  bit last_q[$];
  int exp_q[$];
  int exp_used;

  typedef struct {
    int n;
    int t;
    int nbits;
    logic [31:0] bits;
    int ngaps;
    int g0;
    int g1;
    int g2;
    int bu;
    bit nobr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Bit source, gap sink and hold-stability watcher, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_prev && !rst) begin
        chk("hold_valid", pos_valid, 1);
        chk("hold_data", pos_data, held_data);
        chk("hold_last", pos_last, held_last);
      end
      bit_in    = src[ptr % SRC_N];
      bit_valid = feed_en && (ptr < feed_lim) && (!bv_rand || ($urandom_range(0, 3) != 0));
      if (bit_valid && bit_ready && !rst) ptr++;
      if (bit_ready) seen_br = 1'b1;
      pos_ready = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      if (pos_valid && pos_ready && !rst) begin
        got_q.push_back(int'(pos_data));
        last_q.push_back(pos_last);
      end
      hold_prev = pos_valid && !pos_ready && !rst;
      held_data = pos_data;
      held_last = pos_last;
    end
  end

  // Reference: walk the word with plain integers straight from the gap/skip rules.
  function automatic int pick_u(input int n, input int t);
    int th, q, u;
    th = (t >= 6) ? 1 : (t >= 4) ? 2 : (t == 3) ? 3 : (t == 2) ? 4 : 8;
    q  = (n * th) / 16;
    u  = 2;
    for (int k = 3; k <= 15; k++) if (q > (1 << (k - 1))) u = k;
    return u;
  endfunction

  task automatic model_word(input int n0, input int t0);
    int n, t, delta, p, u, d, i;
    bit skipped;
    exp_q.delete();
    n = n0; t = t0; delta = 0; p = 0;
    while (t > 0) begin
      if (n <= t) begin
        while (t > 0) begin
          exp_q.push_back(delta);
          delta = 0;
          t--;
          if (n > 0) n--;
        end
      end else begin
        u = pick_u(n, t);
        d = 1 << u;
        skipped = 1'b0;
        if (d <= n - t) begin
          skipped = src[p];
          p++;
          if (skipped) begin
            n -= d;
            delta += d;
          end
        end
        if (!skipped) begin
          i = 0;
          for (int k = 0; k < u; k++) begin
            i = i * 2 + int'(src[p]);
            p++;
          end
          if (i > n - t) i = n - t;
          exp_q.push_back(delta + i);
          n -= i + 1;
          t--;
          delta = 0;
        end
      end
    end
    exp_used = p;
  endtask

  task automatic start_word(input int n, input int t);
    got_q.delete();
    last_q.delete();
    ptr = 0;
    seen_br = 1'b0;
    @(negedge clk);
    n_init = NW'(n);
    t_init = TW'(t);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic finish_word(input string nm, input int n, input int t, input bit chk_nobr);
    bit timed_out;
    int sum;
    timed_out = 1'b1;
    for (int c = 0; c < WORD_LIMIT; c++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, WORD_LIMIT);
      finish_tb();
    end
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_gap_count"}, got_q.size(), exp_q.size());
    sum = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_gap%0d", nm, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_last%0d", nm, i), last_q[i], (i == exp_q.size() - 1) ? 1 : 0);
      sum += got_q[i];
    end
    chk({nm, "_no_overrun"}, (sum + t <= n || n < t) ? 1 : 0, 1);
    chk({nm, "_bits_taken"}, ptr, exp_used);
    chk({nm, "_bits_used"}, bits_used, (exp_used > 255) ? 255 : exp_used);
    if (chk_nobr) chk({nm, "_bit_ready_quiet"}, seen_br, 0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  function automatic vec_t mk(input int n, input int t, input int nbits, input logic [31:0] bits,
                              input int ngaps, input int g0, input int g1, input int g2,
                              input int bu, input bit nobr);
    vec_t v;
    v.n = n; v.t = t; v.nbits = nbits; v.bits = bits; v.ngaps = ngaps;
    v.g0 = g0; v.g1 = g1; v.g2 = g2; v.bu = bu; v.nobr = nobr;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    int g[3];
    for (int j = 0; j < SRC_N; j++) src[j] = 1'b0;
    for (int j = 0; j < v.nbits; j++) src[j] = v.bits[v.nbits - 1 - j];
    g[0] = v.g0; g[1] = v.g1; g[2] = v.g2;
    exp_q.delete();
    for (int j = 0; j < v.ngaps; j++) exp_q.push_back(g[j]);
    exp_used = v.bu;
  endtask

  initial begin
    vec_t v;
    logic [GW-1:0] hd;
    bit to;
    int rn, rt;

    vecs.push_back(mk(16, 1, 4, 32'b1011,    1, 11, 0, 0, 4, 1'b0));
    vecs.push_back(mk(3,  3, 0, 32'b0,       3, 0,  0, 0, 0, 1'b1));
    vecs.push_back(mk(3,  1, 2, 32'b11,      1, 2,  0, 0, 2, 1'b0));
    vecs.push_back(mk(10, 0, 0, 32'b0,       0, 0,  0, 0, 0, 1'b1));
    vecs.push_back(mk(16, 2, 7, 32'b0011010, 2, 1, 10, 0, 7, 1'b0));
    vecs.push_back(mk(5,  2, 2, 32'b11,      2, 3,  0, 0, 2, 1'b0));
    vecs.push_back(mk(10, 2, 2, 32'b11,      2, 8,  0, 0, 2, 1'b0));

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_pos_data", pos_data, 0);
    chk("rst_pos_last", pos_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bits_used", bits_used, 0);
    rst = 1'b0;
    feed_en = 1'b1;

    // Table-driven directed words.
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      load_vec(v);
      start_word(v.n, v.t);
      finish_word($sformatf("vec%0d", k), v.n, v.t, v.nobr);
    end

    // Long word, all-zero bits, with a 10-cycle downstream stall and a start while busy.
    for (int j = 0; j < SRC_N; j++) src[j] = 1'b0;
    model_word(65536, 9);
    pr_mode = 2;
    bv_rand = 1'b0;
    start_word(65536, 9);
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (pos_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("big_first_valid_seen", to, 0);
    chk("big_bits_used_first", bits_used, 13);
    chk("big_first_gap", pos_data, 0);
    hd = pos_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_init = NW'(16);
        t_init = TW'(1);
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      chk("stall_valid", pos_valid, 1);
      chk("stall_data", pos_data, hd);
      chk("stall_bit_ready", bit_ready, 0);
      chk("stall_busy", busy, 1);
    end
    start = 1'b0;
    pr_mode = 1;
    bv_rand = 1'b1;
    finish_word("big", 65536, 9, 1'b0);

    // Reset in the middle of READIDX, then the first word again from scratch.
    load_vec(vecs[0]);
    feed_lim = 3;
    start_word(16, 1);
    repeat (20) @(negedge clk);
    chk("mid_bits_used", bits_used, 3);
    chk("mid_bit_ready", bit_ready, 1);
    rst = 1'b1;
    #1;
    chk("midrst_bit_ready", bit_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pos_valid", pos_valid, 0);
    chk("midrst_bits_used", bits_used, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    feed_lim = SRC_N;
    load_vec(vecs[0]);
    start_word(16, 1);
    finish_word("after_rst", 16, 1, 1'b0);

    // Randomized words against the reference walk.
    for (int w = 0; w < 40; w++) begin
      for (int j = 0; j < SRC_N; j++) src[j] = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: rn = $urandom_range(1, 40);
        1: rn = $urandom_range(1, 1000);
        default: rn = $urandom_range(1, 65536);
      endcase
      rt = $urandom_range(0, 9);
      pr_mode = ($urandom_range(0, 1) == 0) ? 0 : 1;
      bv_rand = bit'($urandom_range(0, 1));
      model_word(rn, rt);
      start_word(rn, rt);
      finish_word($sformatf("rnd%0d_n%0d_t%0d", w, rn, rt), rn, rt, 1'b0);
    end

    finish_tb();
  end

endmodule
